// File: rtl/tile_compactor.sv
// Sequential slide engine for the 2048 board: shifts every tile one cell per
// clock toward the selected edge until a full cycle produces no movement.
module tile_compactor #(
   parameter int TILE_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [3:0]        direction,
   input  logic [TILE_W-1:0] matrix [3:0][3:0],
   output logic [TILE_W-1:0] compacted_matrix [3:0][3:0],
   output logic              busy,
   output logic              done,
   output logic              moved,
   output logic [2:0]        steps
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state_q, state_d;
   logic [3:0]        dir_q, dir_d;
   logic [TILE_W-1:0] board_q [3:0][3:0];
   logic [TILE_W-1:0] board_d [3:0][3:0];
   logic [TILE_W-1:0] shifted [3:0][3:0];
   logic [15:0]       cell_moves;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              moved_q, moved_d;
   logic [2:0]        steps_q, steps_d;

   // Each cell looks only at the snapshot: its neighbour toward the edge (dst)
   // and the neighbour that would slide into it (src).
   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_cell
         localparam int R  = gi / 4;
         localparam int C  = gi % 4;
         localparam int CL = (C < 3) ? C + 1 : C;
         localparam int CR = (C > 0) ? C - 1 : C;
         localparam int RU = (R < 3) ? R + 1 : R;
         localparam int RD = (R > 0) ? R - 1 : R;

         logic              has_dst, has_src;
         logic [TILE_W-1:0] cur, dst_v, src_v;

         always_comb begin
            cur     = board_q[R][C];
            has_dst = 1'b0;
            has_src = 1'b0;
            dst_v   = cur;
            src_v   = cur;
            case (dir_q)
               4'b1000: begin
                  has_dst = (C < 3);
                  has_src = (C > 0);
                  dst_v   = board_q[R][CL];
                  src_v   = board_q[R][CR];
               end
               4'b0100: begin
                  has_dst = (R > 0);
                  has_src = (R < 3);
                  dst_v   = board_q[RD][C];
                  src_v   = board_q[RU][C];
               end
               4'b0010: begin
                  has_dst = (R < 3);
                  has_src = (R > 0);
                  dst_v   = board_q[RU][C];
                  src_v   = board_q[RD][C];
               end
               4'b0001: begin
                  has_dst = (C > 0);
                  has_src = (C < 3);
                  dst_v   = board_q[R][CR];
                  src_v   = board_q[R][CL];
               end
               default: ;
            endcase
         end

         assign cell_moves[gi] = has_dst && (cur != '0) && (dst_v == '0);
         assign shifted[R][C]  = (has_src && (cur == '0) && (src_v != '0)) ? src_v :
                                 (cell_moves[gi] ? '0 : cur);
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      board_d = board_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      moved_d = moved_q;
      steps_d = steps_q;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               dir_d   = direction;
               board_d = matrix;
               steps_d = 3'd0;
               moved_d = 1'b0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if ((steps_q == 3'd7) || (cell_moves == '0)) begin
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               board_d = shifted;
               steps_d = steps_q + 3'd1;
               moved_d = 1'b1;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         dir_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         moved_q <= 1'b0;
         steps_q <= '0;
         for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
               board_q[r][c] <= '0;
            end
         end
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         moved_q <= moved_d;
         steps_q <= steps_d;
         board_q <= board_d;
      end
   end

   assign compacted_matrix = board_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign moved            = moved_q;
   assign steps            = steps_q;

endmodule
